// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings and static LED pattern generators for the key-to-LED controller.
package led_ctrl_pkg;

    typedef enum logic [2:0] {
        MODE_ALT   = 3'd0,
        MODE_LOW   = 3'd1,
        MODE_HIGH  = 3'd2,
        MODE_WALK  = 3'd3,
        MODE_BLINK = 3'd4
    } mode_t;

    localparam mode_t MODE_LAST = MODE_BLINK;

    // Pattern functions build into a fixed wide vector; callers slice LED_W bits.
    localparam int PAT_MAX_W = 64;

    // Odd-numbered LEDs lit.
    function automatic logic [PAT_MAX_W-1:0] alt_pat(input int w);
        logic [PAT_MAX_W-1:0] p;
        p = '0;
        for (int i = 0; i < PAT_MAX_W; i++) begin
            if (i < w) p[i] = i[0];
        end
        return p;
    endfunction

    // Lower half of the LED row lit.
    function automatic logic [PAT_MAX_W-1:0] low_pat(input int w);
        logic [PAT_MAX_W-1:0] p;
        p = '0;
        for (int i = 0; i < PAT_MAX_W; i++) begin
            if (i < w / 2) p[i] = 1'b1;
        end
        return p;
    endfunction

    // Complement of low_pat within the w LED bits.
    function automatic logic [PAT_MAX_W-1:0] high_pat(input int w);
        logic [PAT_MAX_W-1:0] p;
        p = '0;
        for (int i = 0; i < PAT_MAX_W; i++) begin
            if ((i < w) && (i >= w / 2)) p[i] = 1'b1;
        end
        return p;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low push-button: 2-flop synchroniser, stability counter, accepted level
// and a single-cycle press pulse on each accepted 1->0 transition.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_press
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_prev_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Two-stage synchroniser; idles high like a released button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= key_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Accept a new level only after DEBOUNCE_CYC consecutive differing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            level_reg <= 1'b1;
        end else if (sync2_reg != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end else begin
            cnt_reg <= '0;
        end
    end

    // Falling edge of the accepted level becomes a one-cycle press pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_prev_reg <= 1'b1;
            press_reg      <= 1'b0;
        end else begin
            level_prev_reg <= level_reg;
            press_reg      <= level_prev_reg & ~level_reg;
        end
    end

    assign key_level = level_reg;
    assign key_press = press_reg;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Key-driven LED pattern controller: debounced keys, mode/hold state machine,
// animation step counter and the registered LED row.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int NUM_KEYS     = 2,
    parameter int LED_W        = 10,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int STEP_CYC     = 12500000
) (
    input  logic                MAX10_CLK1_50,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [LED_W-1:0]    LEDR,
    output logic [2:0]          mode,
    output logic                hold,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_level
);

    localparam int STEP_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);

    localparam logic [PAT_MAX_W-1:0] ALT_FULL  = alt_pat(LED_W);
    localparam logic [PAT_MAX_W-1:0] LOW_FULL  = low_pat(LED_W);
    localparam logic [PAT_MAX_W-1:0] HIGH_FULL = high_pat(LED_W);
    localparam logic [LED_W-1:0] ALT_PAT     = ALT_FULL[LED_W-1:0];
    localparam logic [LED_W-1:0] LOW_PAT     = LOW_FULL[LED_W-1:0];
    localparam logic [LED_W-1:0] HIGH_PAT    = HIGH_FULL[LED_W-1:0];
    localparam logic [LED_W-1:0] WALK_START  = LED_W'(1);
    localparam logic [LED_W-1:0] BLINK_START = {LED_W{1'b1}};

    mode_t             mode_reg, mode_next;
    logic              hold_reg, hold_next;
    logic              load_reg, load_next;
    logic [STEP_W-1:0] step_reg, step_next;
    logic [LED_W-1:0]  led_reg, led_next;
    logic              animated;
    logic              tick;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_debounce (
            .clk      (MAX10_CLK1_50),
            .rst      (reset),
            .key_raw  (KEY[gi]),
            .key_level(key_level[gi]),
            .key_press(key_press[gi])
        );
    end

    // State register; load_reg starts set so the first cycle out of reset shows ALT.
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            mode_reg <= MODE_ALT;
            hold_reg <= 1'b0;
            load_reg <= 1'b1;
            step_reg <= '0;
            led_reg  <= '0;
        end else begin
            mode_reg <= mode_next;
            hold_reg <= hold_next;
            load_reg <= load_next;
            step_reg <= step_next;
            led_reg  <= led_next;
        end
    end

    // Next mode/hold, step counter and LED value. The counter stays at 0 during the
    // start-pattern load so every animation frame, the first included, lasts STEP_CYC.
    always_comb begin
        mode_next = mode_reg;
        hold_next = hold_reg;
        load_next = 1'b0;
        step_next = step_reg;
        led_next  = led_reg;
        tick      = 1'b0;
        animated  = (mode_reg == MODE_WALK) || (mode_reg == MODE_BLINK);

        if (key_press[0]) begin
            mode_next = (mode_reg >= MODE_LAST) ? MODE_ALT : mode_t'(mode_reg + 3'd1);
            hold_next = 1'b0;
            load_next = 1'b1;
        end else if (key_press[1]) begin
            hold_next = ~hold_reg;
        end

        if (key_press[0] || load_reg || !animated) begin
            step_next = '0;
        end else if (!hold_reg) begin
            if (step_reg == STEP_LAST) begin
                step_next = '0;
                tick      = 1'b1;
            end else begin
                step_next = step_reg + 1'b1;
            end
        end

        if (load_reg || !animated) begin
            case (mode_reg)
                MODE_LOW:   led_next = LOW_PAT;
                MODE_HIGH:  led_next = HIGH_PAT;
                MODE_WALK:  led_next = WALK_START;
                MODE_BLINK: led_next = BLINK_START;
                default:    led_next = ALT_PAT;
            endcase
        end else if (tick) begin
            if (mode_reg == MODE_WALK) led_next = {led_reg[LED_W-2:0], led_reg[LED_W-1]};
            else                       led_next = ~led_reg;
        end
    end

    assign LEDR = led_reg;
    assign mode = mode_reg;
    assign hold = hold_reg;

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Parametrised key-to-LED pattern controller for the DE10-Lite board top. It synchronises and debounces the active-low push-buttons and turns presses into single-cycle events. It runs a mode state machine that drives static or animated LED patterns onto LEDR. Extra keys beyond the two control keys are debounced and exported for other logic.

Parameters:
NUM_KEYS, 2, number of active-low keys; must be >= 2; KEY[0]=mode advance, KEY[1]=hold toggle
LED_W, 10, LED output width; must be >= 2
DEBOUNCE_CYC, 500000, consecutive stable cycles before a key level is accepted (10 ms @ 50 MHz)
STEP_CYC, 12500000, animation step period in cycles (0.25 s @ 50 MHz)

Ports:
MAX10_CLK1_50  in   1         sole clock
reset          in   1         asynchronous, active-high reset
KEY            in   NUM_KEYS  raw buttons, active-low, asynchronous to clock
LEDR           out  LED_W     registered LED pattern
mode           out  3         current mode encoding
hold           out  1         1 = animation frozen
key_press      out  NUM_KEYS  one-cycle pulse per accepted press (debounced 1->0)
key_level      out  NUM_KEYS  debounced key level, active-low as KEY

Behaviour:
- Reset (async assert, sync release): LEDR=0, mode=ALT, hold=0, key_press=0, key_level=all 1. Sync flops reset to 1. Debounce and step counters reset to 0.
- Sync: each KEY bit passes through 2 flops.
- Debounce, per key:
  - Counter increments each cycle the synced value differs from key_level.
  - Counter clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYC-1 while still differing, key_level takes the synced value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYC cycles never change key_level.
- key_press[i] is high for exactly the cycle after key_level[i] falls. Releases produce no pulse.
- Modes: ALT=0, LOW=1, HIGH=2, WALK=3, BLINK=4. Encodings 5-7 are unreachable; if entered, they decode as ALT and advance to ALT.
- KEY[0] press: the next edge sets mode to (mode==BLINK ? ALT : mode+1), clears hold, clears the step counter and loads the new mode's start pattern. LEDR shows it one cycle later.
- KEY[1] press: toggles hold. While hold=1, the step counter and LEDR are frozen. Clearing hold resumes from the frozen value and counter.
- Simultaneous KEY[0] and KEY[1] pulses: mode advance wins and hold=0.
- Patterns, LED_W=10 values given:
  - ALT: bit i = i odd (10'h2AA).
  - LOW: low LED_W/2 bits set (10'h01F).
  - HIGH: bitwise complement of LOW (10'h3E0).
  - WALK: starts at 10'h001 and rotates left by 1 on each step tick. Wraps from bit LED_W-1 to bit 0.
  - BLINK: starts all ones and inverts on each step tick.
- Step counter:
  - Runs only in WALK/BLINK with hold=0.
  - Counts 0..STEP_CYC-1; the tick fires on the cycle the count equals STEP_CYC-1, then the count wraps to 0.
  - In static modes the counter is held at 0.
- First cycle after reset release: LEDR loads the ALT pattern.
- Latency from a KEY edge to LEDR update: 2 (sync) + DEBOUNCE_CYC + 1 (pulse) + 1 (mode) + 1 (LEDR) cycles, exact for a clean edge.

Decomposition:
- Package led_ctrl_pkg: mode enum and encodings, MODE_LAST=BLINK, and pattern functions alt_pat(w), low_pat(w), high_pat(w).
- Sub-module key_debounce (2-flop sync, counter, level, press pulse), one instance per key via generate.
- Mode FSM, step counter and LED register live in led_pattern_ctrl.

Test Plan:
Bench parameters: NUM_KEYS=3, LED_W=10, DEBOUNCE_CYC=4, STEP_CYC=3.
1. Reset held 5 cycles -> LEDR=0, mode=0, hold=0, key_level=3'b111. First edge after release -> LEDR=10'h2AA.
2. KEY[0] low 3 cycles, high 3 cycles, repeated 4x -> no key_press, mode=0. Then held low -> single key_press[0] pulse exactly 2+4+1 cycles after the edge, mode=1, LEDR=10'h01F.
3. Four more KEY[0] presses -> LEDR sequence:
   - HIGH: 10'h3E0.
   - WALK: 10'h001, then 10'h002 three cycles later, continuing to 10'h200, then 10'h001.
   - BLINK: 10'h3FF / 10'h000 alternating every 3 cycles.
   - Final press returns to mode 0, LEDR=10'h2AA.
4. In WALK at 10'h008, press KEY[1] -> hold=1, LEDR stays 10'h008 for 20 cycles. Press KEY[1] again -> hold=0, next tick gives 10'h010.
5. With hold=1, KEY[0] and KEY[1] released-to-pressed together -> mode advances once, hold=0. KEY[2] press -> key_press[2] pulse only, mode unchanged.
6. Assert reset mid-debounce of KEY[0] and mid-WALK -> outputs reset the same cycle. After release, with KEY still low, key_level[0] falls after full debounce and produces exactly one pulse.
